// File: rtl/simple_if_reader.sv
// Receiving end of the simple_if data/valid channel: show-ahead FIFO with
// valid/ready on both sides, an accepted-word counter and a sticky writer protocol checker.
module simple_if_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         rx_count,
  output logic                     proto_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;
  logic              stalled;
  logic [DATA_W-1:0] stall_data;

  always_comb begin
    in_ready  = (count != FULL);
    out_valid = (count != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    out_data  = mem[rd_ptr];
  end

  // Storage needs no reset: pointers and count define what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      rx_count <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        rx_count <= rx_count + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A stalled writer must hold valid high and data stable until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stalled    <= 1'b0;
      stall_data <= '0;
      proto_err  <= 1'b0;
    end else begin
      stalled    <= in_valid & ~in_ready;
      stall_data <= in_data;
      if (stalled && (!in_valid || (in_data != stall_data))) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_simple_if_reader.sv
// Self-checking bench for simple_if_reader: scoreboard of pushed words popped
// against the show-ahead output, plus a reference model of count/rx_count/proto_err.
module tb_simple_if_reader;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic        in_ready, out_valid, proto_err;
  logic [7:0]  out_data;
  logic [2:0]  count;
  logic [15:0] rx_count;

  logic        in_ready_4, out_valid_4, proto_err_4;
  logic [7:0]  out_data_4;
  logic [2:0]  count_4;
  logic [3:0]  rx_count_4;

  simple_if_reader #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .rx_count(rx_count), .proto_err(proto_err)
  );

  simple_if_reader #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_4),
    .out_data(out_data_4), .out_valid(out_valid_4), .out_ready(out_ready),
    .count(count_4), .rx_count(rx_count_4), .proto_err(proto_err_4)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sb[$];
  int         m_count = 0;
  int         m_rx = 0;
  logic       m_err = 1'b0;
  logic       m_stalled = 1'b0;
  logic [7:0] m_sdata = '0;

  // Advance one clock: model the cycle, pop/compare the scoreboard, check model state.
  task automatic step();
    logic push, pop;
    logic [7:0] exp;
    push = in_valid && (m_count != DEPTH);
    pop  = (m_count != 0) && out_ready;
    if (m_stalled && (!in_valid || in_data != m_sdata)) m_err = 1'b1;
    m_stalled = in_valid && (m_count == DEPTH);
    m_sdata   = in_data;
    if (pop) begin
      exp = sb.pop_front();
      n_cmp++;
      if (out_data !== exp) begin
        n_bad++;
        $display("FAIL sb_order: out_data=%h expected=%h", out_data, exp);
      end
    end
    if (push) begin
      sb.push_back(in_data);
      m_rx++;
    end
    m_count = m_count + int'(push) - int'(pop);
    @(posedge clk);
    #1;
    n_cmp++;
    if (count !== 3'(m_count) || out_valid !== (m_count != 0) ||
        in_ready !== (m_count != DEPTH) || rx_count !== 16'(m_rx) || proto_err !== m_err) begin
      n_bad++;
      $display("FAIL model_state: count=%0d valid=%b ready=%b rx=%0d err=%b expected count=%0d rx=%0d err=%b",
               count, out_valid, in_ready, rx_count, proto_err, m_count, m_rx, m_err);
    end
  endtask

  // Assert reset mid-cycle and leave it high; caller checks, then calls release_reset.
  task automatic assert_reset();
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    m_count = 0; m_rx = 0; m_err = 1'b0; m_stalled = 1'b0; m_sdata = '0;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_data = 8'h5A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    assert_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0 ||
        rx_count !== 16'd0 || proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: valid=%b ready=%b count=%0d rx=%0d err=%b expected 0 1 0 0 0",
               out_valid, in_ready, count, rx_count, proto_err);
    end
    release_reset();
  endtask

  task automatic test_single_word();
    in_data = 8'hAB; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'hAB || count !== 3'd1 || rx_count !== 16'd1) begin
      n_bad++;
      $display("FAIL single_word: valid=%b data=%h count=%0d rx=%0d expected 1 ab 1 1",
               out_valid, out_data, count, rx_count);
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_bad++;
      $display("FAIL single_pop: valid=%b count=%0d expected 0 0", out_valid, count);
    end
    step();
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_pop_ignored: valid=%b count=%0d expected 0 0", out_valid, count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    logic [7:0] words [4];
    words = '{8'hAB, 8'hCD, 8'hEF, 8'h12};
    assert_reset();
    release_reset();
    for (int i = 0; i < 4; i++) begin
      in_data = words[i]; in_valid = 1'b1;
      step();
    end
    n_cmp++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full: count=%0d ready=%b expected 4 0", count, in_ready);
    end
    in_data = 8'h34; out_ready = 1'b1;
    step();
    n_cmp++;
    if (count !== 3'd3 || in_ready !== 1'b1 || rx_count !== 16'd4) begin
      n_bad++;
      $display("FAIL full_pop_no_push: count=%0d ready=%b rx=%0d expected 3 1 4", count, in_ready, rx_count);
    end
    out_ready = 1'b0;
    step();
    n_cmp++;
    if (count !== 3'd4 || rx_count !== 16'd5) begin
      n_bad++;
      $display("FAIL late_accept: count=%0d rx=%0d expected 4 5", count, rx_count);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if (out_valid !== 1'b0 || rx_count !== 16'd5 || sb.size() != 0 || proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL drain: valid=%b rx=%0d left=%0d err=%b expected 0 5 0 0",
               out_valid, rx_count, sb.size(), proto_err);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(i);
      step();
      n_cmp++;
      if (count !== 3'd1 || out_data !== 8'(i)) begin
        n_bad++;
        $display("FAIL stream_%0d: count=%0d data=%h expected 1 %h", i, count, out_data, 8'(i));
      end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_protocol();
    assert_reset();
    release_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h40 + i);
      step();
    end
    in_data = 8'h55;
    step();
    n_cmp++;
    if (proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_ok: proto_err=%b expected 0", proto_err);
    end
    in_data = 8'h66;
    step();
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_bad++;
      $display("FAIL data_change: proto_err=%b expected 1", proto_err);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: proto_err=%b expected 1", proto_err);
    end
    assert_reset();
    n_cmp++;
    if (proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_reset: proto_err=%b expected 0", proto_err);
    end
    release_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h70 + i);
      step();
    end
    in_data = 8'h55;
    step();
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_bad++;
      $display("FAIL valid_drop: proto_err=%b expected 1", proto_err);
    end
  endtask

  task automatic test_rx_wrap();
    assert_reset();
    release_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(8'hC0 + i);
      step();
    end
    n_cmp++;
    if (rx_count_4 !== 4'd1 || rx_count !== 16'd17) begin
      n_bad++;
      $display("FAIL rx_wrap: rx4=%0d rx16=%0d expected 1 17", rx_count_4, rx_count);
    end
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'hE0 + i);
      step();
    end
    assert_reset();
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 || rx_count !== 16'd0 ||
        count_4 !== 3'd0 || out_valid_4 !== 1'b0 || rx_count_4 !== 4'd0 || in_ready_4 !== 1'b1) begin
      n_bad++;
      $display("FAIL midburst_reset: count=%0d valid=%b rx=%0d count4=%0d valid4=%b rx4=%0d expected zeros",
               count, out_valid, rx_count, count_4, out_valid_4, rx_count_4);
    end
    release_reset();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single_word();
    test_fill();
    test_streaming();
    test_protocol();
    test_rx_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
